d_mem_sub: RTL and testbench
============================

Name: d_mem_sub

Overview:
- Parametrised data memory for the single-cycle MIPS datapath, successor to the word-only data memory.
- Adds sub-word access: byte and halfword loads/stores (LB/LBU/LH/LHU/SB/SH/SW/LW), with little-endian lane steering and sign/zero extension.
- Adds misalignment detection, a registered read-valid flag, and synchronous reset of the output registers.
- Sits between the ALU result/rt operand and the writeback mux.

Parameters:
- tamanho, 32: data word width in bits; must be 32 (four byte lanes).
- enderecamento, 10: word-address bits; depth = 2^enderecamento words.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- Address  in  tamanho  byte address. Bits [enderecamento+1:2] select the word; bits [1:0] select the lane; upper bits are ignored (wrap).
- WriteData  in  tamanho  store data, taken from the low bits (byte = [7:0], half = [15:0]).
- MemWrite  in  1  store request this cycle.
- MemRead  in  1  load request this cycle.
- Size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
- Unsigned  in  1  1 = zero-extend loads, 0 = sign-extend; ignored for word.
- ReadData  out  tamanho  registered, extended load result.
- ReadValid  out  1  high for the cycle after an accepted load.
- Misaligned  out  1  registered error flag for the access of the previous cycle.

Behaviour:
- Reset (sampled at posedge Clock):
  - ReadData = 0, ReadValid = 0, Misaligned = 0.
  - Memory contents are not cleared.
  - A MemWrite or MemRead in the same cycle as Reset is discarded: no array write, no flags.
- Alignment rule: an access is misaligned when Size=01 and Address[0]=1, when Size=10 and Address[1:0]!=0, or when Size=11.
- Stores, when MemWrite=1, aligned, and Reset=0:
  - Byte-lane enables are computed from Size and Address[1:0], little-endian: lane k is bits [8k+7:8k] at Address[1:0]=k.
  - SB writes 1 lane, SH writes lanes {0,1} or {2,3}, SW writes all 4.
  - Unselected lanes keep their old value.
  - The write takes effect at posedge.
- Loads, when MemRead=1, aligned, and Reset=0:
  - At posedge, the word is read and the selected lane(s) are shifted to bit 0, then extended per Unsigned.
  - Result is registered into ReadData; ReadValid=1 for exactly one cycle.
  - Latency: data is visible in the cycle after the request.
- ReadData holding: when there is no accepted load, ReadData holds its previous value and ReadValid=0.
- Misaligned accesses:
  - No array write and no ReadData update; ReadValid=0.
  - Misaligned=1 in the next cycle; otherwise Misaligned=0 after each clock.
  - Misaligned is evaluated only when MemRead or MemWrite is asserted.
- Simultaneous MemRead and MemWrite:
  - Both are performed.
  - Read-first: ReadData returns the word content from before the write, including same-address cases.
  - Misaligned applies to both.
- Back-to-back loads: one load per cycle; ReadValid stays high continuously.
- Address wrap: address 4*2^enderecamento aliases word 0.

Test Plan:
- Reset, then SW 0x8000_00FF to addr 0x10, then LW 0x10 -> next cycle ReadData=0x8000_00FF, ReadValid=1; following idle cycle ReadValid=0, ReadData held.
- SW 0x1122_3344 @0x20; SB 0xAA @0x21; LW 0x20 -> ReadData=0x1122_AA44. Then LB 0x21 -> 0xFFFF_FFAA; LBU 0x21 -> 0x0000_00AA.
- SH 0x8001 @0x22 over 0x1122_AA44; LH 0x22 -> 0xFFFF_8001; LHU 0x22 -> 0x0000_8001; LW 0x20 -> 0x8001_AA44.
- SW 0xDEAD_BEEF @0x31 (misaligned) -> Misaligned=1 next cycle, ReadValid=0, word 0x30 unchanged. LH @0x33 -> Misaligned=1, ReadData unchanged. Size=11 -> Misaligned=1.
- MemRead+MemWrite same cycle, SW 0x5555_5555 @0x40 over old 0x1234_5678 -> ReadData=0x1234_5678; next LW 0x40 -> 0x5555_5555.
- Reset asserted together with SW 0x0F0F_0F0F @0x50 (old 0x1) -> after reset LW 0x50 = 0x1; ReadData/ReadValid/Misaligned were 0 during reset.

Source files
------------

// File: rtl/d_mem_sub.sv
// rtl/d_mem_sub.sv - byte-addressable data memory with sub-word loads/stores,
// registered read data, read-valid and misalignment flags.
module d_mem_sub #(
    parameter int tamanho       = 32,
    parameter int enderecamento = 10
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [tamanho-1:0] Address,
    input  logic [tamanho-1:0] WriteData,
    input  logic               MemWrite,
    input  logic               MemRead,
    input  logic [1:0]         Size,
    input  logic               Unsigned,
    output logic [tamanho-1:0] ReadData,
    output logic               ReadValid,
    output logic               Misaligned
);

    localparam int depth = 2 ** enderecamento;

    logic [tamanho-1:0]       mem [0:depth-1];

    logic [enderecamento-1:0] word_idx;
    logic [1:0]               lane;
    logic                     misaligned_c;
    logic                     load_ok;
    logic                     store_ok;
    logic [3:0]               byte_en;
    logic [tamanho-1:0]       wdata;
    logic [tamanho-1:0]       rd_word;
    logic [tamanho-1:0]       shifted;
    logic [tamanho-1:0]       load_val;

    // Address bits above the word index are ignored so the array wraps.
    logic unused_addr_bits;
    assign unused_addr_bits = ^Address[tamanho-1:enderecamento+2];

    assign word_idx = Address[enderecamento+1:2];
    assign lane     = Address[1:0];

    always_comb begin
        misaligned_c = 1'b0;
        case (Size)
            2'b00:   misaligned_c = 1'b0;
            2'b01:   misaligned_c = lane[0];
            2'b10:   misaligned_c = (lane != 2'b00);
            default: misaligned_c = 1'b1;
        endcase
    end

    assign load_ok  = MemRead  && !misaligned_c && !Reset;
    assign store_ok = MemWrite && !misaligned_c && !Reset;

    // Store data is replicated across lanes so each enabled lane sees its bytes.
    always_comb begin
        byte_en = 4'b0000;
        wdata   = WriteData;
        case (Size)
            2'b00: begin
                byte_en = 4'b0001 << lane;
                wdata   = {4{WriteData[7:0]}};
            end
            2'b01: begin
                byte_en = lane[1] ? 4'b1100 : 4'b0011;
                wdata   = {2{WriteData[15:0]}};
            end
            2'b10: begin
                byte_en = 4'b1111;
                wdata   = WriteData;
            end
            default: begin
                byte_en = 4'b0000;
                wdata   = WriteData;
            end
        endcase
    end

    assign rd_word = mem[word_idx];
    assign shifted = rd_word >> {lane, 3'b000};

    always_comb begin
        load_val = shifted;
        case (Size)
            2'b00:   load_val = Unsigned ? {{(tamanho-8){1'b0}}, shifted[7:0]}
                                         : {{(tamanho-8){shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = Unsigned ? {{(tamanho-16){1'b0}}, shifted[15:0]}
                                         : {{(tamanho-16){shifted[15]}}, shifted[15:0]};
            default: load_val = rd_word;
        endcase
    end

    // The read above samples the array before this write lands: read-first.
    always_ff @(posedge Clock) begin
        if (store_ok) begin
            for (int k = 0; k < 4; k++) begin
                if (byte_en[k]) begin
                    mem[word_idx][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            ReadData   <= '0;
            ReadValid  <= 1'b0;
            Misaligned <= 1'b0;
        end else begin
            ReadValid  <= load_ok;
            Misaligned <= (MemRead || MemWrite) && misaligned_c;
            if (load_ok) begin
                ReadData <= load_val;
            end
        end
    end

endmodule

// File: tb/tb_d_mem_sub.sv
// tb/tb_d_mem_sub.sv - randomized bench for d_mem_sub against a byte-array model,
// plus literal expectations from hand-worked access sequences.
module tb_d_mem_sub;

    localparam int W     = 32;
    localparam int AB    = 6;
    localparam int NBYTE = 4 * (2 ** AB);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  addr = '0;
    logic [W-1:0]  wd = '0;
    logic          wr = 1'b0;
    logic          rd = 1'b0;
    logic [1:0]    sz = 2'b10;
    logic          uns = 1'b0;
    logic [W-1:0]  rdata;
    logic          rvalid;
    logic          mis;

    d_mem_sub #(.tamanho(W), .enderecamento(AB)) dut (
        .Clock(clk), .Reset(rst), .Address(addr), .WriteData(wd),
        .MemWrite(wr), .MemRead(rd), .Size(sz), .Unsigned(uns),
        .ReadData(rdata), .ReadValid(rvalid), .Misaligned(mis)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]   mem_m [0:NBYTE-1];
    logic [W-1:0] nx_rd = '0, exp_rd = '0;
    logic         nx_rv = 1'b0, exp_rv = 1'b0;
    logic         nx_mis = 1'b0, exp_mis = 1'b0;
    bit           checking = 1'b0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            chk("ReadValid", {31'b0, rvalid}, {31'b0, exp_rv});
            chk("Misaligned", {31'b0, mis}, {31'b0, exp_mis});
            chk("ReadData", rdata, exp_rd);
        end
    end

    function automatic bit bad_align(input logic [1:0] s, input logic [W-1:0] a);
        return (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0) || (s == 2'd3);
    endfunction

    // Apply one cycle's inputs and advance the model to what the outputs must be next.
    task automatic drive(input bit r, input bit w, input bit re, input logic [1:0] s,
                         input bit u, input logic [W-1:0] a, input logic [W-1:0] d);
        int n, base;
        logic [W-1:0] v;
        bit m;
        rst = r; wr = w; rd = re; sz = s; uns = u; addr = a; wd = d;
        if (r) begin
            nx_rd = '0; nx_rv = 1'b0; nx_mis = 1'b0;
        end else begin
            m      = (re || w) && bad_align(s, a);
            nx_mis = m;
            nx_rv  = re && !m;
            n      = 1 << s;
            base   = int'(a % NBYTE);
            if (re && !m) begin
                v = '0;
                for (int i = 0; i < n; i++) v = v | (W'(mem_m[base+i]) << (8*i));
                if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
                nx_rd = v;
            end
            if (w && !m) begin
                for (int i = 0; i < n; i++) mem_m[base+i] = d[8*i +: 8];
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        exp_rd = nx_rd; exp_rv = nx_rv; exp_mis = nx_mis;
        checking = 1'b1;
    endtask

    task automatic op(input bit r, input bit w, input bit re, input logic [1:0] s,
                      input bit u, input logic [W-1:0] a, input logic [W-1:0] d);
        drive(r, w, re, s, u, a, d);
        tick();
    endtask

    task automatic idle();
        op(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, '0, '0);
    endtask

    task automatic lit(input string name, input logic [W-1:0] want_rd, input bit want_rv,
                       input bit want_mis);
        chk({name, ".rd"}, rdata, want_rd);
        chk({name, ".rv"}, {31'b0, rvalid}, {31'b0, want_rv});
        chk({name, ".mis"}, {31'b0, mis}, {31'b0, want_mis});
    endtask

    initial begin
        for (int i = 0; i < NBYTE; i++) mem_m[i] = 8'h00;
        drive(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, '0, '0);
        @(posedge clk); #1;
        tick();
        lit("reset", 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < NBYTE / 4; i++) op(0, 1, 0, 2'b10, 0, W'(4*i), 32'h0);

        op(0, 1, 0, 2'b10, 0, 32'h10, 32'h8000_00FF);
        op(0, 0, 1, 2'b10, 0, 32'h10, '0);
        lit("lw10", 32'h8000_00FF, 1'b1, 1'b0);
        idle();
        lit("hold", 32'h8000_00FF, 1'b0, 1'b0);

        op(0, 1, 0, 2'b10, 0, 32'h20, 32'h1122_3344);
        op(0, 1, 0, 2'b00, 0, 32'h21, 32'h0000_00AA);
        op(0, 0, 1, 2'b10, 0, 32'h20, '0);
        lit("lw20", 32'h1122_AA44, 1'b1, 1'b0);
        op(0, 0, 1, 2'b00, 0, 32'h21, '0);
        lit("lb21", 32'hFFFF_FFAA, 1'b1, 1'b0);
        op(0, 0, 1, 2'b00, 1, 32'h21, '0);
        lit("lbu21", 32'h0000_00AA, 1'b1, 1'b0);

        op(0, 1, 0, 2'b01, 0, 32'h22, 32'h0000_8001);
        op(0, 0, 1, 2'b01, 0, 32'h22, '0);
        lit("lh22", 32'hFFFF_8001, 1'b1, 1'b0);
        op(0, 0, 1, 2'b01, 1, 32'h22, '0);
        lit("lhu22", 32'h0000_8001, 1'b1, 1'b0);
        op(0, 0, 1, 2'b10, 0, 32'h20, '0);
        lit("lw20b", 32'h8001_AA44, 1'b1, 1'b0);

        op(0, 1, 0, 2'b10, 0, 32'h30, 32'h0BAD_F00D);
        op(0, 1, 0, 2'b10, 0, 32'h31, 32'hDEAD_BEEF);
        lit("swmis", 32'h8001_AA44, 1'b0, 1'b1);
        op(0, 0, 1, 2'b10, 0, 32'h30, '0);
        lit("lw30", 32'h0BAD_F00D, 1'b1, 1'b0);
        op(0, 0, 1, 2'b01, 0, 32'h33, '0);
        lit("lhmis", 32'h0BAD_F00D, 1'b0, 1'b1);
        op(0, 0, 1, 2'b11, 0, 32'h30, '0);
        lit("sz11", 32'h0BAD_F00D, 1'b0, 1'b1);

        op(0, 1, 0, 2'b10, 0, 32'h40, 32'h1234_5678);
        op(0, 1, 1, 2'b10, 0, 32'h40, 32'h5555_5555);
        lit("rdfirst", 32'h1234_5678, 1'b1, 1'b0);
        op(0, 0, 1, 2'b10, 0, 32'h40, '0);
        lit("lw40", 32'h5555_5555, 1'b1, 1'b0);

        op(0, 1, 0, 2'b10, 0, 32'h50, 32'h0000_0001);
        op(1, 1, 1, 2'b10, 0, 32'h50, 32'h0F0F_0F0F);
        lit("rstop", 32'h0, 1'b0, 1'b0);
        op(0, 0, 1, 2'b10, 0, 32'h50, '0);
        lit("lw50", 32'h0000_0001, 1'b1, 1'b0);

        op(0, 0, 1, 2'b10, 0, 32'h140, '0);
        lit("wrap", 32'h5555_5555, 1'b1, 1'b0);

        for (int c = 0; c < 3000; c++) begin
            op($urandom_range(0, 49) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
               2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               W'($urandom_range(0, 511)), $urandom);
        end

        idle();
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
